me_search_ctrl: RTL and testbench

- Sequencer for the full-search motion estimation datapath.
- Steps the 16 processing elements through 16 candidate rows of 16 vectors each (vectorx 0..15, vectory 0..15).
- Drives the reference/search memory addresses, per-PE clear/accumulate strobes, and the one-hot peready, vectorx, vectory and compstart consumed by the best-distortion comparator directly downstream.
- Produces a one-cycle done pulse when all 256 vectors have been evaluated.

---
 rtl/me_search_ctrl_if.sv | 43 ++++
 rtl/me_search_ctrl.sv | 137 +++++++++++++
 tb/tb_me_search_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/me_search_ctrl_if.sv
// rtl/me_search_ctrl_if.sv - control/result bundle of me_search_ctrl; abort present when ME_SEARCH_CTRL_ABORT_EN is defined
interface me_search_ctrl_if #(
    parameter int NUM_PE = 16
);
    logic              start;
`ifdef ME_SEARCH_CTRL_ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              done;
    logic              compstart;
    logic [NUM_PE-1:0] pe_clear;
    logic [NUM_PE-1:0] pe_accum;
    logic [NUM_PE-1:0] peready;
    logic [3:0]        vectorx;
    logic [3:0]        vectory;
    logic [7:0]        addr_r;
    logic [8:0]        addr_s;

`ifdef ME_SEARCH_CTRL_ABORT_EN
    modport master (
        output start, abort,
        input  busy, done, compstart, pe_clear, pe_accum, peready,
               vectorx, vectory, addr_r, addr_s
    );
    modport slave (
        input  start, abort,
        output busy, done, compstart, pe_clear, pe_accum, peready,
               vectorx, vectory, addr_r, addr_s
    );
`else
    modport master (
        output start,
        input  busy, done, compstart, pe_clear, pe_accum, peready,
               vectorx, vectory, addr_r, addr_s
    );
    modport slave (
        input  start,
        output busy, done, compstart, pe_clear, pe_accum, peready,
               vectorx, vectory, addr_r, addr_s
    );
`endif
endinterface

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion estimation sequencer; optional abort input via ME_SEARCH_CTRL_ABORT_EN
module me_search_ctrl #(
    parameter int NUM_PE   = 16,
    parameter int NUM_PASS = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    me_search_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [8:0] T_LAST    = 9'(NUM_PE + 255);
    localparam logic [3:0] LAST_PASS = 4'(NUM_PASS - 1);

    state_t      state, state_n;
    logic [8:0]  t, t_n;
    logic [3:0]  pass, pass_n;
    logic        abort_req;

`ifdef ME_SEARCH_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            t     <= '0;
            pass  <= '0;
        end else begin
            state <= state_n;
            t     <= t_n;
            pass  <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        t_n     = t;
        pass_n  = pass;
        case (state)
            IDLE: begin
                if (bus.start && !abort_req) begin
                    state_n = RUN;
                    t_n     = '0;
                    pass_n  = '0;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_n = IDLE;
                    t_n     = '0;
                    pass_n  = '0;
                end else if (t == T_LAST) begin
                    if (pass == LAST_PASS) begin
                        state_n = DONE;
                    end else begin
                        pass_n = pass + 4'd1;
                        t_n    = '0;
                    end
                end else begin
                    t_n = t + 9'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with the current t/pass.
    logic              busy_n, done_n, compstart_n;
    logic [NUM_PE-1:0] clear_n, accum_n, ready_n;
    logic [3:0]        vectorx_n, vectory_n;
    logic [7:0]        addr_r_n;
    logic [8:0]        addr_s_n;
    logic [9:0]        te;

    always_comb begin
        busy_n      = 1'b0;
        done_n      = (state_n == DONE);
        compstart_n = 1'b0;
        clear_n     = '0;
        accum_n     = '0;
        ready_n     = '0;
        vectorx_n   = '0;
        vectory_n   = '0;
        addr_r_n    = '0;
        addr_s_n    = '0;
        te          = {1'b0, t_n};
        if (state_n == RUN) begin
            busy_n      = 1'b1;
            compstart_n = 1'b1;
            vectory_n   = pass_n;
            for (int i = 0; i < NUM_PE; i++) begin
                accum_n[i] = (te >= 10'(i)) && (te <= 10'(i) + 10'd255);
                clear_n[i] = (te == 10'(i));
                ready_n[i] = (te == 10'(i) + 10'd256);
            end
            if (t_n >= 9'd256) begin
                // Drain: addresses hold their t=255 values while the last PEs finish.
                vectorx_n = t_n[3:0];
                addr_r_n  = 8'hFF;
                addr_s_n  = {{1'b0, pass_n} + 5'd15, 4'hF};
            end else begin
                addr_r_n  = t_n[7:0];
                addr_s_n  = {{1'b0, t_n[7:4]} + {1'b0, pass_n}, t_n[3:0]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.compstart <= 1'b0;
            bus.pe_clear  <= '0;
            bus.pe_accum  <= '0;
            bus.peready   <= '0;
            bus.vectorx   <= '0;
            bus.vectory   <= '0;
            bus.addr_r    <= '0;
            bus.addr_s    <= '0;
        end else begin
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.compstart <= compstart_n;
            bus.pe_clear  <= clear_n;
            bus.pe_accum  <= accum_n;
            bus.peready   <= ready_n;
            bus.vectorx   <= vectorx_n;
            bus.vectory   <= vectory_n;
            bus.addr_r    <= addr_r_n;
            bus.addr_s    <= addr_s_n;
        end
    end
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - directed self-checking bench for me_search_ctrl (abort cases under ME_SEARCH_CTRL_ABORT_EN)
module tb_me_search_ctrl;
    logic clock = 1'b0;
    logic reset_n;

    me_search_ctrl_if #(.NUM_PE(16)) bus ();

    me_search_ctrl #(.NUM_PE(16), .NUM_PASS(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int g, run_cycles, rdy_cnt, bad_onehot, k, done_cnt, busy_cnt;
    bit got_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.start = 1'b0;
`ifdef ME_SEARCH_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_compstart", 32'(bus.compstart), 0);
        check("rst_pe", {bus.pe_clear, bus.pe_accum}, 0);
        check("rst_peready", 32'(bus.peready), 0);
        check("rst_addr", {bus.vectorx, bus.vectory, bus.addr_r, bus.addr_s}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", 32'(bus.busy), 0);

        // Single search with a stray start pulse at t=50.
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        g = 0; run_cycles = 0; rdy_cnt = 0; bad_onehot = 0; got_done = 1'b0;
        while (!got_done && g < 5000) begin
            if (bus.busy) run_cycles++;
            if (bus.peready != 0) begin
                rdy_cnt++;
                if (!$onehot(bus.peready)) bad_onehot++;
            end
            if (g == 0) begin
                check("g0_clear", 32'(bus.pe_clear), 32'h0001);
                check("g0_accum", 32'(bus.pe_accum), 32'h0001);
                check("g0_addr_r", 32'(bus.addr_r), 0);
                check("g0_addr_s", 32'(bus.addr_s), 0);
                check("g0_compstart", 32'(bus.compstart), 1);
            end
            if (g == 15) begin
                check("g15_accum", 32'(bus.pe_accum), 32'hFFFF);
                check("g15_clear", 32'(bus.pe_clear), 32'h8000);
            end
            if (g == 50) bus.start = 1'b1;
            if (g == 51) bus.start = 1'b0;
            if (g == 256) begin
                check("t256_peready", 32'(bus.peready), 32'h0001);
                check("t256_vx", 32'(bus.vectorx), 0);
                check("t256_vy", 32'(bus.vectory), 0);
                check("t256_accum", 32'(bus.pe_accum), 32'hFFFE);
                check("t256_addr_r", 32'(bus.addr_r), 32'hFF);
                check("t256_addr_s", 32'(bus.addr_s), 32'h0FF);
            end
            if (g == 271) begin
                check("t271_peready", 32'(bus.peready), 32'h8000);
                check("t271_vx", 32'(bus.vectorx), 15);
                check("t271_accum", 32'(bus.pe_accum), 0);
            end
            if (g == 272) begin
                check("p1_vy", 32'(bus.vectory), 1);
                check("p1_clear", 32'(bus.pe_clear), 32'h0001);
                check("p1_addr_s", 32'(bus.addr_s), 32'h010);
            end
            if (g == 3 * 272) begin
                check("p3_vy", 32'(bus.vectory), 3);
                check("p3_addr_s", 32'(bus.addr_s), 32'h030);
            end
            if (g == 3 * 272 + 255) begin
                check("p3t255_addr_r", 32'(bus.addr_r), 32'hFF);
                check("p3t255_addr_s", 32'(bus.addr_s), 32'h12F);
            end
            if (bus.done) got_done = 1'b1;
            else begin
                @(negedge clock);
                g++;
            end
        end
        check("run1_done_seen", 32'(got_done), 1);
        check("run1_done_index", 32'(g), 4352);
        check("run1_cycles", 32'(run_cycles), 4352);
        check("run1_ready_cnt", 32'(rdy_cnt), 256);
        check("run1_onehot_err", 32'(bad_onehot), 0);
        check("done_busy", 32'(bus.busy), 0);
        check("done_compstart", 32'(bus.compstart), 0);

        // start during DONE is lost.
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("post_done_pulse", 32'(bus.done), 0);
        check("start_in_done_busy", 32'(bus.busy), 0);
        @(negedge clock);
        check("start_in_done_busy2", 32'(bus.busy), 0);

        // start held high: back-to-back runs with one IDLE cycle between.
        bus.start = 1'b1;
        k = 0;
        while (!bus.busy && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("held_run_start", 32'(bus.busy), 1);
        g = 0; got_done = 1'b0;
        while (!got_done && g < 5000) begin
            if (bus.done) got_done = 1'b1;
            else begin
                @(negedge clock);
                g++;
            end
        end
        check("held_run_len", 32'(g), 4352);
        @(negedge clock);
        check("held_gap_busy", 32'(bus.busy), 0);
        check("held_gap_done", 32'(bus.done), 0);
        @(negedge clock);
        check("held_rerun_busy", 32'(bus.busy), 1);
        check("held_rerun_clear", 32'(bus.pe_clear), 32'h0001);
        bus.start = 1'b0;

        // Reset mid-run at pass 2, t=100.
        repeat (2 * 272 + 100) @(negedge clock);
        check("mid_vy", 32'(bus.vectory), 2);
        check("mid_addr_r", 32'(bus.addr_r), 100);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_compstart", 32'(bus.compstart), 0);
        check("midrst_outs", {bus.pe_clear, bus.pe_accum}, 0);
        check("midrst_addr", {bus.peready, bus.addr_r, bus.vectory}, 0);
        reset_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        repeat (5000) begin
            @(negedge clock);
            if (bus.done) done_cnt++;
            if (bus.busy || bus.peready != 0) busy_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 0);
        check("midrst_no_activity", 32'(busy_cnt), 0);

`ifdef ME_SEARCH_CTRL_ABORT_EN
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        check("abort_blocks_start", 32'(bus.busy), 0);
        bus.start = 1'b0;
        @(negedge clock);
        check("abort_idle", 32'(bus.busy), 0);
        bus.abort = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("abort_run_start", 32'(bus.busy), 1);
        repeat (5 * 272 + 260) @(negedge clock);
        check("abort_pre_vy", 32'(bus.vectory), 5);
        check("abort_pre_peready", 32'(bus.peready), 32'h0010);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_peready", 32'(bus.peready), 0);
        check("abort_compstart", 32'(bus.compstart), 0);
        check("abort_done", 32'(bus.done), 0);
        done_cnt = 0;
        repeat (3000) begin
            @(negedge clock);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
